mem_responder: RTL and testbench

- Memory-side target for the CPU's Pmmu load/store interface. Services one read or write request at a time from a word-organised RAM.
- Inserts a programmable number of wait states, reporting them through a busy/ready handshake.
- Performs RV32I byte-lane steering: LB/LH/LW/LBU/LHU extraction with sign/zero extension, and SB/SH/SW partial-word merge.
- Flags misaligned, illegal or out-of-range accesses.

---
 rtl/mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_mem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-organised RAM target for the CPU load/store port: one access at a time,
// programmable wait states, RV32I byte-lane steering and access fault detection.
`timescale 1ns/1ps
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WORDS  = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  mem_rd_i,
  input  logic                  mem_wr_i,
  input  logic [DATA_WIDTH-1:0] byte_addr_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  mem_busy_o,
  output logic                  mem_rdy_o,
  output logic                  fault_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [DATA_WIDTH-3:0] WORD_LIMIT = (DATA_WIDTH-2)'(ADDR_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            count_reg, count_next;
  logic [DATA_WIDTH-1:0] addr_reg, wd_reg;
  logic [2:0]            f3_reg;
  logic                  rd_op_reg, wr_op_reg;
  logic                  accept, exec;

  // With zero wait states the access executes on the accepting edge, so it
  // must see the live request rather than the latched copy.
  logic [DATA_WIDTH-1:0] acc_addr, acc_wd;
  logic [2:0]            acc_f3;
  logic                  acc_rd, acc_wr;

  assign acc_addr = (state_reg == S_IDLE) ? byte_addr_i : addr_reg;
  assign acc_wd   = (state_reg == S_IDLE) ? wd_i        : wd_reg;
  assign acc_f3   = (state_reg == S_IDLE) ? funct3_i    : f3_reg;
  assign acc_rd   = (state_reg == S_IDLE) ? mem_rd_i    : rd_op_reg;
  assign acc_wr   = (state_reg == S_IDLE) ? mem_wr_i    : wr_op_reg;

  logic [DATA_WIDTH-3:0] word_idx;
  logic [AW-1:0]         ram_idx;
  logic [1:0]            lane;
  logic                  is_half, is_word, f3_bad, acc_fault;

  assign word_idx = acc_addr[DATA_WIDTH-1:2];
  assign ram_idx  = word_idx[AW-1:0];
  assign lane     = acc_addr[1:0];
  assign is_half  = (acc_f3[1:0] == 2'b01);
  assign is_word  = (acc_f3[1:0] == 2'b10);
  assign f3_bad   = (acc_f3 == 3'b011) || (acc_f3[2:1] == 2'b11);

  assign acc_fault = (acc_rd && acc_wr) || f3_bad || (acc_wr && acc_f3[2])
                  || (is_half && acc_addr[0]) || (is_word && (lane != 2'b00))
                  || (word_idx >= WORD_LIMIT);

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    exec       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_rd_i || mem_wr_i) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            exec       = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_WAIT;
            count_next = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (count_reg == 4'd0) begin
          exec       = 1'b1;
          state_next = S_DONE;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Byte-lane write enables and lane-replicated write data
  logic [NB-1:0]         byte_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  we;

  always_comb begin
    byte_en = '1;
    wdata   = acc_wd;
    case (acc_f3[1:0])
      2'b00: begin
        byte_en = NB'(1) << lane;
        wdata   = {NB{acc_wd[7:0]}};
      end
      2'b01: begin
        byte_en = acc_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
        wdata   = {(NB/2){acc_wd[15:0]}};
      end
      default: ;
    endcase
  end

  assign we = exec && acc_wr && !acc_fault && !reset_i;

  logic [DATA_WIDTH-1:0] rword;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] lane_mem [ADDR_WORDS];
      always_ff @(posedge clk_i) begin
        if (we && byte_en[gi]) lane_mem[ram_idx] <= wdata[8*gi +: 8];
      end
      assign rword[8*gi +: 8] = lane_mem[ram_idx];
    end
  endgenerate

  // Load extraction with sign/zero extension
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [DATA_WIDTH-1:0] rdata_ext;

  assign rbyte = rword[8*lane +: 8];
  assign rhalf = rword[16*acc_addr[1] +: 16];

  always_comb begin
    rdata_ext = '0;
    case (acc_f3)
      3'b000:  rdata_ext = {{(DATA_WIDTH-8){rbyte[7]}}, rbyte};
      3'b100:  rdata_ext = {{(DATA_WIDTH-8){1'b0}}, rbyte};
      3'b001:  rdata_ext = {{(DATA_WIDTH-16){rhalf[15]}}, rhalf};
      3'b101:  rdata_ext = {{(DATA_WIDTH-16){1'b0}}, rhalf};
      3'b010:  rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg  <= S_IDLE;
      count_reg  <= 4'd0;
      addr_reg   <= '0;
      wd_reg     <= '0;
      f3_reg     <= 3'd0;
      rd_op_reg  <= 1'b0;
      wr_op_reg  <= 1'b0;
      rd_o       <= '0;
      mem_busy_o <= 1'b0;
      mem_rdy_o  <= 1'b0;
      fault_o    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      if (accept) begin
        addr_reg  <= byte_addr_i;
        wd_reg    <= wd_i;
        f3_reg    <= funct3_i;
        rd_op_reg <= mem_rd_i;
        wr_op_reg <= mem_wr_i;
      end
      mem_busy_o <= (state_next == S_WAIT);
      mem_rdy_o  <= (state_next == S_DONE);
      fault_o    <= exec && acc_fault;
      if (exec && acc_rd) rd_o <= acc_fault ? '0 : rdata_ext;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: two instances (2 and 0 wait states) share
// the address/data bus; expected completions are queued and checked on mem_rdy_o.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] addr, wd;
  logic [2:0]  f3;
  logic [31:0] rdo2, rdo0;
  logic        busy2, rdy2, flt2, busy0, rdy0, flt0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_WIDTH(32), .ADDR_WORDS(1024), .WAIT_STATES(2)) dut (
    .clk_i(clk), .reset_i(reset), .mem_rd_i(rd2), .mem_wr_i(wr2),
    .byte_addr_i(addr), .funct3_i(f3), .wd_i(wd), .rd_o(rdo2),
    .mem_busy_o(busy2), .mem_rdy_o(rdy2), .fault_o(flt2)
  );

  mem_responder #(.DATA_WIDTH(32), .ADDR_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk_i(clk), .reset_i(reset), .mem_rd_i(rd0), .mem_wr_i(wr0),
    .byte_addr_i(addr), .funct3_i(f3), .wd_i(wd), .rd_o(rdo0),
    .mem_busy_o(busy0), .mem_rdy_o(rdy0), .fault_o(flt0)
  );

  typedef struct {
    logic [31:0] rd;
    logic        flt;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it cycle by cycle to completion.
  // hold keeps mem_rd_i asserted through WAIT/DONE to confirm it is ignored.
  task automatic run_req(input bit z, input bit r, input bit w, input logic [31:0] a,
                         input logic [2:0] f, input logic [31:0] d, input logic [31:0] exp_rd,
                         input bit exp_flt, input bit chk_rd, input bit hold, input string name);
    int   ws;
    exp_t e;
    exp_t got;
    logic b, y, fl;
    logic [31:0] ro;
    ws = z ? 0 : 2;
    @(negedge clk);
    addr = a; f3 = f; wd = d;
    if (z) begin rd0 = r; wr0 = w; end
    else   begin rd2 = r; wr2 = w; end
    e.rd = exp_rd; e.flt = exp_flt; e.chk_rd = chk_rd;
    sb.push_back(e);
    for (int k = 1; k <= ws + 1; k++) begin
      @(negedge clk);
      rd0 = 1'b0; wr0 = 1'b0; wr2 = 1'b0;
      rd2 = hold && (k >= 2);
      b  = z ? busy0 : busy2;
      y  = z ? rdy0  : rdy2;
      fl = z ? flt0  : flt2;
      ro = z ? rdo0  : rdo2;
      check($sformatf("%s busy@%0d", name, k), 32'(b), 32'(k <= ws));
      check($sformatf("%s rdy@%0d", name, k), 32'(y), 32'(k == ws + 1));
      if (k == ws + 1) begin
        if (sb.size() == 0) begin
          check({name, " scoreboard"}, 32'(sb.size()), 32'd1);
        end else begin
          got = sb.pop_front();
          check({name, " fault"}, 32'(fl), 32'(got.flt));
          if (got.chk_rd) check({name, " rd_o"}, ro, got.rd);
        end
      end
    end
    @(negedge clk);
    rd2 = 1'b0;
    check({name, " rdy pulse end"}, 32'(z ? rdy0 : rdy2), 32'd0);
    check({name, " fault pulse end"}, 32'(z ? flt0 : flt2), 32'd0);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check({name, " no 2nd rdy"}, 32'(rdy2), 32'd0);
        check({name, " no 2nd busy"}, 32'(busy2), 32'd0);
      end
    end
    $display("%-14s ws=%0d rd=%b wr=%b addr=%h f3=%b wd=%h -> rd_o=%h fault=%b",
             name, ws, r, w, a, f, d, ro, fl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    addr = '0; wd = '0; f3 = 3'b010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd_o", rdo2, 32'd0);
    check("reset busy", 32'(busy2), 32'd0);
    check("reset rdy", 32'(rdy2), 32'd0);
    check("reset fault", 32'(flt2), 32'd0);
    check("reset rdy ws0", 32'(rdy0), 32'd0);
    reset = 1'b0;

    //        z  r  w  addr        f3      wd            exp_rd        flt chk hold
    run_req(0, 0, 1, 32'h40,  3'b010, 32'hDEADBEEF, 32'h0,        0, 0, 0, "SW 40");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'hDEADBEEF, 0, 1, 0, "LW 40");
    run_req(0, 0, 1, 32'h41,  3'b000, 32'hFFFFFF7F, 32'h0,        0, 0, 0, "SB 41");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'hDEAD7FEF, 0, 1, 0, "LW 40 b");
    run_req(0, 1, 0, 32'h43,  3'b000, 32'h0,        32'hFFFFFFDE, 0, 1, 0, "LB 43");
    run_req(0, 1, 0, 32'h43,  3'b100, 32'h0,        32'h000000DE, 0, 1, 0, "LBU 43");
    run_req(0, 1, 0, 32'h41,  3'b000, 32'h0,        32'h0000007F, 0, 1, 0, "LB 41");
    run_req(0, 1, 0, 32'h40,  3'b000, 32'h0,        32'hFFFFFFEF, 0, 1, 0, "LB 40");
    run_req(0, 1, 0, 32'h42,  3'b001, 32'h0,        32'hFFFFDEAD, 0, 1, 0, "LH 42");
    run_req(0, 1, 0, 32'h42,  3'b101, 32'h0,        32'h0000DEAD, 0, 1, 0, "LHU 42");
    run_req(0, 1, 0, 32'h40,  3'b001, 32'h0,        32'h00007FEF, 0, 1, 0, "LH 40");
    run_req(0, 0, 1, 32'h42,  3'b001, 32'hABCD1234, 32'h0,        0, 0, 0, "SH 42");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'h12347FEF, 0, 1, 0, "LW 40 c");
    run_req(0, 1, 0, 32'h42,  3'b010, 32'h0,        32'h0,        1, 1, 0, "LW 42 misal");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'h12347FEF, 0, 1, 0, "LW 40 d");
    run_req(0, 0, 1, 32'h41,  3'b001, 32'h5555,     32'h12347FEF, 1, 1, 0, "SH 41 misal");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'h12347FEF, 0, 1, 0, "LW 40 e");
    run_req(0, 1, 0, 32'h1000, 3'b010, 32'h0,       32'h0,        1, 1, 0, "LW 1000 oor");
    run_req(0, 0, 1, 32'hFFC, 3'b010, 32'hCAFEF00D, 32'h0,        0, 0, 0, "SW FFC");
    run_req(0, 1, 0, 32'hFFC, 3'b010, 32'h0,        32'hCAFEF00D, 0, 1, 0, "LW FFC");
    run_req(0, 1, 1, 32'h40,  3'b010, 32'h0,        32'h0,        1, 0, 0, "RD+WR");
    run_req(0, 1, 0, 32'h40,  3'b011, 32'h0,        32'h0,        1, 1, 0, "L f3=011");
    run_req(0, 0, 1, 32'h40,  3'b100, 32'h0,        32'h0,        1, 0, 0, "S f3=100");
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'h12347FEF, 0, 1, 1, "LW 40 hold");

    run_req(1, 0, 1, 32'h10,  3'b010, 32'h55AA1234, 32'h0,        0, 0, 0, "ws0 SW 10");
    run_req(1, 1, 0, 32'h10,  3'b010, 32'h0,        32'h55AA1234, 0, 1, 0, "ws0 LW 10");
    run_req(1, 1, 0, 32'h12,  3'b001, 32'h0,        32'h000055AA, 0, 1, 0, "ws0 LH 12");

    // Abort a store in its second wait cycle with an asynchronous reset.
    @(negedge clk);
    addr = 32'h40; f3 = 3'b010; wd = 32'h0; wr2 = 1'b1;
    @(negedge clk);
    wr2 = 1'b0;
    check("abort busy w1", 32'(busy2), 32'd1);
    @(negedge clk);
    check("abort busy w2", 32'(busy2), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async rst busy", 32'(busy2), 32'd0);
    check("async rst rdy", 32'(rdy2), 32'd0);
    check("async rst fault", 32'(flt2), 32'd0);
    check("async rst rd_o", rdo2, 32'd0);
    $display("reset asserted mid-SW 40 -> busy=%b rd_o=%h", busy2, rdo2);
    @(negedge clk);
    reset = 1'b0;
    check("post rst rdy", 32'(rdy2), 32'd0);
    run_req(0, 1, 0, 32'h40,  3'b010, 32'h0,        32'h12347FEF, 0, 1, 0, "LW 40 post");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
